// File: rtl/serial_divider_pkg.sv
// rtl/serial_divider_pkg.sv - shared types and constants for the serial divider
//
// Purpose: state encoding, default operand width and the divide-by-zero
//          quotient constant used by the serial divider core.
// Ports:   none (package).
package serial_divider_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Quotient reported for a zero divisor; sliced down to XLEN where used.
   localparam logic [63:0] DBZ_QUOTIENT = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FIXUP = 2'd2
   } state_e;

endpackage

// File: rtl/serial_divider_if.sv
// rtl/serial_divider_if.sv - request/result bundle between register block and divider
//
// Purpose: groups the start request, operands and results of the divider.
// Signals: start_i, dividend_i, divisor_i  (register block -> core)
//          quotient_o, remainder_o, busy_o, fini_o, dbz_o  (core -> register block)
// Modports: master = register block side, slave = divider core side.
interface serial_divider_if
   import serial_divider_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);
   logic            start_i;
   logic [XLEN-1:0] dividend_i;
   logic [XLEN-1:0] divisor_i;
   logic [XLEN-1:0] quotient_o;
   logic [XLEN-1:0] remainder_o;
   logic            busy_o;
   logic            fini_o;
   logic            dbz_o;

   modport master (
      output start_i, dividend_i, divisor_i,
      input  quotient_o, remainder_o, busy_o, fini_o, dbz_o
   );

   modport slave (
      input  start_i, dividend_i, divisor_i,
      output quotient_o, remainder_o, busy_o, fini_o, dbz_o
   );

endinterface

// File: rtl/serial_divider_step.sv
// rtl/serial_divider_step.sv - one combinational restoring-division step
//
// Purpose: shifts {rem, dvd} left by one, trial-subtracts the divisor and
//          restores on a negative result.
// Ports:   rem_i     partial remainder
//          dvd_i     dividend shift register (MSB enters the remainder)
//          divisor_i divisor
//          rem_o     next partial remainder
//          dvd_o     dvd_i shifted left, without the new LSB
//          qbit_o    new quotient bit (the LSB to append to dvd_o)
module serial_divider_step
   import serial_divider_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] dvd_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-2:0] dvd_o,
   output logic            qbit_o
);

   logic [XLEN:0] rem_shift;
   logic [XLEN:0] trial;

   always_comb begin
      // One extra bit keeps the borrow visible even for divisors >= 2^(XLEN-1).
      rem_shift = {rem_i, dvd_i[XLEN-1]};
      trial     = rem_shift - {1'b0, divisor_i};
      qbit_o    = ~trial[XLEN];
      rem_o     = qbit_o ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
      dvd_o     = dvd_i[XLEN-2:0];
   end

endmodule

// File: rtl/serial_divider_core.sv
// rtl/serial_divider_core.sv - radix-2 restoring divider, one quotient bit per clock
//
// Purpose: XLEN-bit unsigned divide (signed when SERIAL_DIVIDER_SIGNED_EN is
//          defined). Results and flags are registered and held until the next
//          completion.
// Ports:   clk_i    clock, rising edge
//          reset_i  asynchronous active-high reset
//          div_if   slave side of serial_divider_if:
//                   start_i/dividend_i/divisor_i in,
//                   quotient_o/remainder_o/busy_o/fini_o/dbz_o out
// Config:  SERIAL_DIVIDER_SIGNED_EN - two's complement operands, adds the
//          FIXUP state (latency XLEN+1 instead of XLEN).
module serial_divider_core
   import serial_divider_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int CNTW = $clog2(XLEN)
) (
   input  logic           clk_i,
   input  logic           reset_i,
   serial_divider_if.slave div_if
);

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);

   state_e          state_q;
   logic [CNTW-1:0] count_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] dvd_q;
   logic [XLEN-1:0] div_q;
   logic            zero_div_q;
   logic [XLEN-1:0] quotient_q;
   logic [XLEN-1:0] remainder_q;
   logic            busy_q;
   logic            fini_q;
   logic            dbz_q;

   logic [XLEN-1:0] rem_d;
   logic [XLEN-2:0] dvd_shift_d;
   logic            qbit_d;

`ifdef SERIAL_DIVIDER_SIGNED_EN
   logic [XLEN-1:0] orig_dvd_q;
   logic            dvd_neg_q;
   logic            div_neg_q;

   // Most-negative maps to itself, which read as unsigned is its magnitude.
   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
      return v[XLEN-1] ? -v : v;
   endfunction
`endif

   serial_divider_step #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_q),
      .dvd_i     (dvd_q),
      .divisor_i (div_q),
      .rem_o     (rem_d),
      .dvd_o     (dvd_shift_d),
      .qbit_o    (qbit_d)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         div_q       <= '0;
         zero_div_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         fini_q      <= 1'b0;
         dbz_q       <= 1'b0;
`ifdef SERIAL_DIVIDER_SIGNED_EN
         orig_dvd_q  <= '0;
         dvd_neg_q   <= 1'b0;
         div_neg_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (div_if.start_i) begin
`ifdef SERIAL_DIVIDER_SIGNED_EN
                  dvd_q      <= abs_val(div_if.dividend_i);
                  div_q      <= abs_val(div_if.divisor_i);
                  dvd_neg_q  <= div_if.dividend_i[XLEN-1];
                  div_neg_q  <= div_if.divisor_i[XLEN-1];
                  orig_dvd_q <= div_if.dividend_i;
`else
                  dvd_q      <= div_if.dividend_i;
                  div_q      <= div_if.divisor_i;
`endif
                  zero_div_q <= (div_if.divisor_i == '0);
                  rem_q      <= '0;
                  count_q    <= CNT_LAST;
                  fini_q     <= 1'b0;
                  dbz_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_RUN;
               end
            end

            ST_RUN: begin
               rem_q   <= rem_d;
               dvd_q   <= {dvd_shift_d, qbit_d};
               count_q <= count_q - CNTW'(1);
               if (count_q == '0) begin
`ifdef SERIAL_DIVIDER_SIGNED_EN
                  state_q <= ST_FIXUP;
`else
                  // A zero divisor needs no special case here: every trial
                  // succeeds, giving all-ones and the dividend as remainder.
                  quotient_q  <= {dvd_shift_d, qbit_d};
                  remainder_q <= rem_d;
                  dbz_q       <= zero_div_q;
                  fini_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
`endif
               end
            end

`ifdef SERIAL_DIVIDER_SIGNED_EN
            ST_FIXUP: begin
               if (zero_div_q) begin
                  // The magnitude path would return |dividend|; report the original.
                  quotient_q  <= XLEN'(DBZ_QUOTIENT);
                  remainder_q <= orig_dvd_q;
               end else begin
                  quotient_q  <= (dvd_neg_q ^ div_neg_q) ? -dvd_q : dvd_q;
                  remainder_q <= dvd_neg_q ? -rem_q : rem_q;
               end
               dbz_q   <= zero_div_q;
               fini_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
`endif

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign div_if.quotient_o  = quotient_q;
   assign div_if.remainder_o = remainder_q;
   assign div_if.busy_o      = busy_q;
   assign div_if.fini_o      = fini_q;
   assign div_if.dbz_o       = dbz_q;

endmodule

// File: tb/tb_serial_divider_core.sv
// tb/tb_serial_divider_core.sv - scoreboard bench for serial_divider_core
module tb_serial_divider_core;
   import serial_divider_pkg::*;

   localparam int XLEN = 32;
`ifdef SERIAL_DIVIDER_SIGNED_EN
   localparam int LAT = XLEN + 1;
`else
   localparam int LAT = XLEN;
`endif

   typedef struct {
      logic [XLEN-1:0] q;
      logic [XLEN-1:0] r;
      logic            dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_divider_if #(.XLEN(XLEN)) dif ();

   serial_divider_core #(.XLEN(XLEN)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .div_if  (dif)
   );

   exp_t            sb[$];
   int              total = 0;
   int              bad = 0;
   logic [XLEN-1:0] last_q;
   logic [XLEN-1:0] last_r;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   exp_t            drop;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      exp_t e;
      e.dbz = (b == '0);
      if (b == '0) begin
         e.q = '1;
         e.r = a;
      end else begin
`ifdef SERIAL_DIVIDER_SIGNED_EN
         if (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
            e.q = a;
            e.r = '0;
         end else begin
            e.q = XLEN'($signed(a) / $signed(b));
            e.r = XLEN'($signed(a) % $signed(b));
         end
`else
         e.q = a / b;
         e.r = a % b;
`endif
      end
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge E0.
   task automatic drive_start(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit hold);
      dif.start_i    = 1'b1;
      dif.dividend_i = a;
      dif.divisor_i  = b;
      @(negedge clk);
      if (!hold) begin
         dif.start_i    = 1'b0;
         dif.dividend_i = $urandom;
         dif.divisor_i  = $urandom;
      end
      sb.push_back(model(a, b));
      check("start_busy", dif.busy_o, 1);
      check("start_fini", dif.fini_o, 0);
   endtask

   // Counts edges after E0 until fini_o, then pops and compares the result.
   task automatic wait_done(input string tag, input int inject_at);
      int   k = 0;
      exp_t e;
      while (dif.fini_o !== 1'b1 && k < LAT + 4) begin
         if (inject_at > 0 && k == inject_at - 1) begin
            dif.start_i    = 1'b1;
            dif.dividend_i = 32'd12345;
            dif.divisor_i  = 32'd11;
         end
         if (inject_at > 0 && k == inject_at) dif.start_i = 1'b0;
         if (k == 3) begin
            check({tag, "_hold_q"}, dif.quotient_o, last_q);
            check({tag, "_hold_r"}, dif.remainder_o, last_r);
         end
         @(negedge clk);
         k++;
         if (dif.fini_o !== 1'b1) check({tag, "_busy"}, dif.busy_o, 1);
      end
      check({tag, "_latency"}, k, LAT);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      if (dif.fini_o === 1'b1) begin
         check({tag, "_q"}, dif.quotient_o, e.q);
         check({tag, "_r"}, dif.remainder_o, e.r);
         check({tag, "_dbz"}, dif.dbz_o, e.dbz);
         check({tag, "_busy_done"}, dif.busy_o, 0);
         last_q = e.q;
         last_r = e.r;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: no finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      dif.start_i    = 1'b0;
      dif.dividend_i = '0;
      dif.divisor_i  = '0;
      last_q         = '0;
      last_r         = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_q", dif.quotient_o, 0);
      check("rst_r", dif.remainder_o, 0);
      check("rst_busy", dif.busy_o, 0);
      check("rst_fini", dif.fini_o, 0);
      check("rst_dbz", dif.dbz_o, 0);

      drive_start(32'd100, 32'd7, 1'b0);
      wait_done("d100_7", 0);
      check("d100_7_q_const", dif.quotient_o, 14);
      check("d100_7_r_const", dif.remainder_o, 2);

      drive_start(32'hFFFF_FFFF, 32'd0, 1'b0);
      wait_done("dbz", 0);
      check("dbz_q_const", dif.quotient_o, 32'hFFFF_FFFF);
      check("dbz_r_const", dif.remainder_o, 32'hFFFF_FFFF);
      check("dbz_flag_const", dif.dbz_o, 1);

      @(negedge clk);
      drive_start(32'd1000, 32'd3, 1'b0);
      wait_done("inject", 5);
      check("inject_q_const", dif.quotient_o, 333);
      check("inject_r_const", dif.remainder_o, 1);

      // Reset while the operation is in RUN.
      drive_start(32'hDEAD_BEEF, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_q", dif.quotient_o, 0);
      check("midrst_r", dif.remainder_o, 0);
      check("midrst_busy", dif.busy_o, 0);
      check("midrst_fini", dif.fini_o, 0);
      check("midrst_dbz", dif.dbz_o, 0);
      drop   = sb.pop_back();
      last_q = '0;
      last_r = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive_start(32'd9, 32'd3, 1'b0);
      wait_done("d9_3", 0);
      check("d9_3_q_const", dif.quotient_o, 3);
      check("d9_3_r_const", dif.remainder_o, 0);

      drive_start(32'd0, 32'd5, 1'b0);
      wait_done("zero_dvd", 0);
      drive_start(32'd5, 32'd9, 1'b0);
      wait_done("small_dvd", 0);
      drive_start(32'h1234_5678, 32'd1, 1'b0);
      wait_done("div_one", 0);
      drive_start(32'hFFFF_FFF0, 32'h8000_0001, 1'b0);
      wait_done("big_div", 0);
      for (int i = 0; i < 4; i++) begin
         op_a = $urandom;
         op_b = $urandom_range(1, 2000);
         drive_start(op_a, op_b, 1'b0);
         wait_done("rand", 0);
      end

`ifdef SERIAL_DIVIDER_SIGNED_EN
      drive_start(-32'sd7, 32'd2, 1'b0);
      wait_done("s_m7_2", 0);
      check("s_m7_2_q_const", dif.quotient_o, 32'hFFFF_FFFD);
      check("s_m7_2_r_const", dif.remainder_o, 32'hFFFF_FFFF);
      drive_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_done("s_ovf", 0);
      check("s_ovf_q_const", dif.quotient_o, 32'h8000_0000);
      check("s_ovf_r_const", dif.remainder_o, 0);
      check("s_ovf_dbz_const", dif.dbz_o, 0);
      drive_start(-32'sd8, 32'd0, 1'b0);
      wait_done("s_dbz", 0);
      drive_start(32'd7, -32'sd2, 1'b0);
      wait_done("s_7_m2", 0);
      drive_start(-32'sd100, -32'sd7, 1'b0);
      wait_done("s_m100_m7", 0);
`endif

      // start_i held high: the completion-edge start is ignored, the next one taken.
      drive_start(32'd50, 32'd5, 1'b1);
      wait_done("held1", 0);
      sb.push_back(model(32'd50, 32'd5));
      @(negedge clk);
      check("held_restart_fini", dif.fini_o, 0);
      check("held_restart_busy", dif.busy_o, 1);
      wait_done("held2", 0);
      dif.start_i = 1'b0;
      @(negedge clk);
      check("held_idle_busy", dif.busy_o, 0);
      check("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_divider_core.md
# serial_divider_core

Radix-2 restoring divider that performs a full XLEN-bit unsigned divide, or a signed divide when configured, one quotient bit per clock. It sits directly downstream of the Wishbone-facing serial divider register block, which drives it as follows:

- Inputs: the DIVIDEND and DIVISOR registers and the single-cycle START pulse.
- Outputs consumed: QUOTIENT, REMAINDER and FINI, which the register block shows as read-only CSRs and on the logic analyser.

## Interface
Parameters:
- XLEN, 32: operand and result width; must be ≥ 2.
- CNTW, $clog2(XLEN): iteration counter width.

Ports:
- clk_i  input  1  single clock domain; all state changes on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  single-cycle request; sampled only in IDLE.
- dividend_i  input  XLEN  dividend; captured on an accepted start.
- divisor_i  input  XLEN  divisor; captured on an accepted start.
- quotient_o  output  XLEN  registered quotient; reset 0.
- remainder_o  output  XLEN  registered remainder; reset 0.
- busy_o  output  1  high while an operation is in flight; reset 0.
- fini_o  output  1  high from completion until the next accepted start; reset 0.
- dbz_o  output  1  last completed operation had divisor == 0; reset 0; same lifetime as fini_o.

## Operation
State machine: IDLE, RUN, FIXUP (FIXUP exists only with signed support).

- **IDLE + start_i:**
  - Latch the operands; in signed mode latch their absolute values and the two sign bits.
  - Clear the partial remainder, set count = XLEN-1.
  - Clear fini_o and dbz_o, set busy_o.
  - Go to RUN.
- **RUN, each cycle:**
  - Shift {rem, dvd} left by 1.
  - trial = rem_shifted − divisor, computed at XLEN+1 bits.
  - If trial is non-negative: rem = trial[XLEN-1:0] and the new quotient bit = 1; otherwise the quotient bit = 0.
  - Decrement count.
- **RUN exit** (after the step at count == 0):
  - Unsigned: load quotient_o/remainder_o, set fini_o, clear busy_o, go to IDLE.
  - Signed: go to FIXUP.
- **FIXUP:**
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Load the outputs, set fini_o, clear busy_o, go to IDLE.
- **Divide by zero:**
  - Result: quotient = all ones, remainder = original dividend, dbz_o = 1.
  - The unsigned path produces this result naturally.
  - In signed mode FIXUP forces this result instead of applying the sign correction.
  - Same latency as a normal operation.
- **Signed overflow** (most-negative / −1): quotient = most-negative, remainder = 0; no flag.
- **start_i outside IDLE** (including the completion edge): ignored, no error.
- **Between completions:** outputs hold the previous result; they are never updated mid-operation.
- **Reset, including mid-operation:** returns to IDLE with every output 0; the result of the in-flight operation is lost.

## Timing
- Let E0 be the edge at which start_i is sampled in IDLE.
  - busy_o is high after E0.
  - Unsigned: results and fini_o are valid after edge E0+XLEN.
  - Signed: results and fini_o are valid after edge E0+XLEN+1.
- busy_o and fini_o are never high at the same time.
- A new start is accepted at the first edge after fini_o rises.
- Throughput: one operation per XLEN+1 cycles unsigned, XLEN+2 cycles signed.
- Inputs need to be stable only at E0.
- All outputs come directly from registers; there is no combinational path from any input to any output.

## Configuration
- SERIAL_DIVIDER_SIGNED_EN defined:
  - Operands are two's complement.
  - Absolute-value capture, the FIXUP state and the signed divide-by-zero override are all built.
  - Latency is XLEN+1 cycles.
- SERIAL_DIVIDER_SIGNED_EN undefined:
  - Operation is unsigned only; the FIXUP state and the sign logic are absent.
  - Latency is XLEN cycles.

## Structure
- Package serial_divider_pkg holds:
  - the state encoding (IDLE, RUN, FIXUP);
  - the default XLEN;
  - the divide-by-zero quotient constant (all ones).
- One sub-module, serial_divider_step: the combinational restoring step.
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd, quotient bit.
  - Keeps the subtract/compare separate from the FSM and counter.

## Test plan
- 100 / 7 unsigned → quotient 14, remainder 2, dbz_o 0. fini_o rises exactly XLEN edges after E0, and busy_o is high across those edges.
- 0xFFFFFFFF / 0 → quotient 0xFFFFFFFF, remainder 0xFFFFFFFF, dbz_o 1, normal latency.
- Second start_i pulse at E0+5 with other operands → ignored; the result still matches the first operands.
- reset_i asserted mid-RUN at E0+10 → all outputs 0 immediately. A subsequent 9 / 3 → quotient 3, remainder 0.
- Signed build:
  - −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - Both complete at E0+XLEN+1.
- start_i held every cycle → the start at the completion edge is ignored; the next edge is accepted and clears fini_o.
